// File: rtl/alu_pkg.sv
// ALU shared types: operation encoding and shift-amount width.
// Latency: none (types only). Backpressure: not applicable.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_SLTU = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_AND  = 4'b1001
  } alu_op_e;

  localparam int ALU_SHAMT_W = 5;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA, present only when ALU_SHIFT_EN is defined.
// Latency: combinational. Backpressure: none.
`ifdef ALU_SHIFT_EN
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       data,
  input  logic [ALU_SHAMT_W-1:0] shamt,
  input  alu_op_e                op,
  output logic [WIDTH-1:0]       result
);

  always_comb begin
    result = '0;
    case (op)
      OP_SLL:  result = data << shamt;
      OP_SRL:  result = data >> shamt;
      OP_SRA:  result = $signed(data) >>> shamt;
      default: result = '0;
    endcase
  end

endmodule
`endif

// File: rtl/alu.sv
// RV32-style ALU: combinational ALU_Out plus a one-cycle registered copy with zero flag.
// Latency 0 (ALU_Out) / 1 (ALU_Out_q); no backpressure. Shifts only with ALU_SHIFT_EN.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALU_sel,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Out_q,
  output logic             zero_q,
  output logic             out_valid
);

  alu_op_e          op;
  logic [WIDTH-1:0] alu_out;
  logic             lt_signed;
  logic             lt_unsigned;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d;
  logic             valid_d, valid_q;

  assign op          = alu_op_e'(ALU_sel);
  assign lt_signed   = $signed(reg1) < $signed(reg2);
  assign lt_unsigned = reg1 < reg2;

`ifdef ALU_SHIFT_EN
  logic [WIDTH-1:0] shift_res;

  alu_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .data  (reg1),
    .shamt (reg2[ALU_SHAMT_W-1:0]),
    .op    (op),
    .result(shift_res)
  );
`endif

  // Unused and (without the shifter) shift selects fall through to zero.
  always_comb begin
    alu_out = '0;
    case (op)
      OP_ADD:  alu_out = reg1 + reg2;
      OP_SUB:  alu_out = reg1 - reg2;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_XOR:  alu_out = reg1 ^ reg2;
      OP_OR:   alu_out = reg1 | reg2;
      OP_AND:  alu_out = reg1 & reg2;
`ifdef ALU_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: alu_out = shift_res;
`endif
      default: alu_out = '0;
    endcase
  end

  assign ALU_Out = alu_out;

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    if (in_valid) begin
      result_d = alu_out;
      zero_d   = (alu_out == '0);
      valid_d  = 1'b1;
    end
  end

  // Reset wins over a same-edge valid input, dropping that result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign ALU_Out_q = result_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table, hand-written register sequences, random vs arithmetic model.
module tb_alu;

  localparam logic [63:0] MOD32 = 64'h1_0000_0000;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ALU_sel;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        in_valid;
  logic [31:0] ALU_Out;
  logic [31:0] ALU_Out_q;
  logic        zero_q;
  logic        out_valid;

  int checks;
  int errors;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ALU_sel  (ALU_sel),
    .reg1     (reg1),
    .reg2     (reg2),
    .in_valid (in_valid),
    .ALU_Out  (ALU_Out),
    .ALU_Out_q(ALU_Out_q),
    .zero_q   (zero_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference computed from the arithmetic meaning of each operation.
  function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, p2, r;
    longint          sa, sb, q;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    p2 = 1;
    for (int i = 0; i < 32; i++) if (i < int'(b % 32)) p2 = p2 * 2;
    r = 0;
    case (sel)
      4'd0: r = (ua + ub) % MOD32;
      4'd1: r = (ua + MOD32 - ub) % MOD32;
      4'd3: r = (sa < sb) ? 1 : 0;
      4'd4: r = (ua < ub) ? 1 : 0;
      4'd5: r = a ^ b;
      4'd8: r = a | b;
      4'd9: r = a & b;
`ifdef ALU_SHIFT_EN
      4'd2: r = (ua * p2) % MOD32;
      4'd6: r = ua / p2;
      4'd7: begin
        q = (sa >= 0) ? sa / longint'(p2) : -((-sa + longint'(p2) - 1) / longint'(p2));
        r = longint'(q) % MOD32;
        r = (q >= 0) ? r : ((MOD32 - ((-q) % MOD32)) % MOD32);
      end
`endif
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [5];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
    return $urandom;
  endfunction

  logic [31:0] m_q;
  logic        m_z;
  logic        m_v;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ALU_sel  = 4'd0;
    reg1     = '0;
    reg2     = '0;

    vecs.push_back('{"add_1_1",     4'b0000, 32'd1,          32'd1,          32'd2});
    vecs.push_back('{"add_0_1",     4'b0000, 32'd0,          32'd1,          32'd1});
    vecs.push_back('{"add_1_22",    4'b0000, 32'd1,          32'd22,         32'd23});
    vecs.push_back('{"sub_wrap",    4'b0001, 32'd0,          32'd1,          32'hFFFF_FFFF});
    vecs.push_back('{"add_wrap",    4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0});
    vecs.push_back('{"slt_neg",     4'b0011, 32'hFFFF_FFFF,  32'd1,          32'd1});
    vecs.push_back('{"sltu_big",    4'b0100, 32'hFFFF_FFFF,  32'd1,          32'd0});
    vecs.push_back('{"xor",         4'b0101, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'hFF00_EDCB});
    vecs.push_back('{"or",          4'b1000, 32'hF000_0001,  32'h0000_0F10,  32'hF000_0F11});
    vecs.push_back('{"and",         4'b1001, 32'hF0F0_FFFF,  32'h3C3C_0101,  32'h3030_0101});
    vecs.push_back('{"sel_1111",    4'b1111, 32'd5,          32'd7,          32'd0});
    vecs.push_back('{"sel_1010",    4'b1010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0});
`ifdef ALU_SHIFT_EN
    vecs.push_back('{"sra_sign",    4'b0111, 32'h8000_0000,  32'h24,         32'hF800_0000});
    vecs.push_back('{"srl_zero",    4'b0110, 32'h8000_0000,  32'h24,         32'h0800_0000});
    vecs.push_back('{"sll_shamt",   4'b0010, 32'd1,          32'h21,         32'd2});
`else
    vecs.push_back('{"sra_off",     4'b0111, 32'h8000_0000,  32'h24,         32'd0});
    vecs.push_back('{"srl_off",     4'b0110, 32'h8000_0000,  32'h24,         32'd0});
    vecs.push_back('{"sll_off",     4'b0010, 32'd1,          32'h21,         32'd0});
`endif

    // Table applied under reset: ALU_Out must not depend on clk or rst_n.
    foreach (vecs[i]) begin
      ALU_sel = vecs[i].sel;
      reg1    = vecs[i].a;
      reg2    = vecs[i].b;
      #10;
      check(vecs[i].name, ALU_Out, vecs[i].exp);
    end

    @(negedge clk);
    check("rst_q",     ALU_Out_q,           32'd0);
    check("rst_zero",  {31'd0, zero_q},     32'd0);
    check("rst_valid", {31'd0, out_valid},  32'd0);

    // Nonzero result then SUB 5-5 back to back, then an idle cycle that must hold.
    rst_n = 1'b1; in_valid = 1'b1; ALU_sel = 4'b0000; reg1 = 32'd3; reg2 = 32'd4;
    @(negedge clk);
    check("b2b_first_q",    ALU_Out_q,          32'd7);
    check("b2b_first_zero", {31'd0, zero_q},    32'd0);
    check("b2b_first_vld",  {31'd0, out_valid}, 32'd1);
    ALU_sel = 4'b0001; reg1 = 32'd5; reg2 = 32'd5;
    @(negedge clk);
    check("sub_eq_q",    ALU_Out_q,          32'd0);
    check("sub_eq_zero", {31'd0, zero_q},    32'd1);
    check("sub_eq_vld",  {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; ALU_sel = 4'b0000; reg1 = 32'd9; reg2 = 32'd1;
    @(negedge clk);
    check("idle_vld",  {31'd0, out_valid}, 32'd0);
    check("idle_q",    ALU_Out_q,          32'd0);
    check("idle_zero", {31'd0, zero_q},    32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; reg1 = 32'd100;
    @(negedge clk);
    check("hold_q",    ALU_Out_q,          32'd10);
    check("hold_zero", {31'd0, zero_q},    32'd0);

    // Reset on the same edge as a valid input discards that result.
    rst_n = 1'b0; in_valid = 1'b1; ALU_sel = 4'b0000; reg1 = 32'd5; reg2 = 32'd5;
    @(negedge clk);
    check("rst_pri_q",    ALU_Out_q,          32'd0);
    check("rst_pri_zero", {31'd0, zero_q},    32'd0);
    check("rst_pri_vld",  {31'd0, out_valid}, 32'd0);
    check("rst_comb",     ALU_Out,            32'd10);
    ALU_sel = 4'b1111;
    #1;
    check("rst_sel_1111", ALU_Out,            32'd0);

    // Random traffic against the model, with occasional resets.
    m_q = '0; m_z = 1'b0; m_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      check("rnd_q",    ALU_Out_q,          m_q);
      check("rnd_zero", {31'd0, zero_q},    {31'd0, m_z});
      check("rnd_vld",  {31'd0, out_valid}, {31'd0, m_v});
      rst_n    = ($urandom_range(19) != 0);
      in_valid = ($urandom_range(3) != 0);
      ALU_sel  = 4'($urandom_range(15));
      reg1     = pick_operand();
      reg2     = pick_operand();
      #1;
      check("rnd_comb", ALU_Out, ref_alu(ALU_sel, reg1, reg2));
      @(posedge clk);
      if (!rst_n) begin
        m_q = '0; m_z = 1'b0; m_v = 1'b0;
      end else if (in_valid) begin
        m_q = ref_alu(ALU_sel, reg1, reg2);
        m_z = (m_q == 32'd0);
        m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is required to be supported.
REQ-002 Port: clk  input  1  single clock; all sequential logic on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: ALU_sel  input  4  operation select.
REQ-005 Port: reg1  input  WIDTH  operand A (rs1 value).
REQ-006 Port: reg2  input  WIDTH  operand B (rs2 value).
REQ-007 Port: in_valid  input  1  operands/select valid this cycle.
REQ-008 Port: ALU_Out  output  WIDTH  combinational result.
REQ-009 Port: ALU_Out_q  output  WIDTH  registered result.
REQ-010 Port: zero_q  output  1  registered flag, set when the registered result is zero.
REQ-011 Port: out_valid  output  1  ALU_Out_q and zero_q hold a valid result.

Function
REQ-012 ALU_Out SHALL be a pure combinational function of ALU_sel, reg1 and reg2, with zero cycles of latency and no dependence on clk, rst_n or in_valid.
REQ-013 Encoding SHALL be: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
REQ-014 ADD/SUB SHALL wrap modulo 2^WIDTH; carry and overflow SHALL be discarded.
REQ-015 Shift amount SHALL be reg2[4:0]; reg2[31:5] SHALL be ignored; SRA SHALL replicate reg1[31].
REQ-016 SLT SHALL give 1 if reg1 < reg2 (two's complement) else 0; SLTU SHALL do the same unsigned; upper bits SHALL be zero.
REQ-017 ALU_sel 1010..1111 SHALL give ALU_Out = 0.
REQ-018 On each rising clk edge with rst_n=1 and in_valid=1: ALU_Out_q <= ALU_Out, zero_q <= (ALU_Out == 0), out_valid <= 1.
REQ-019 On a rising edge with rst_n=1 and in_valid=0: ALU_Out_q and zero_q SHALL hold, out_valid <= 0.
REQ-020 Registered latency SHALL be exactly one cycle; back-to-back valid inputs SHALL each produce one result on consecutive cycles.

Reset
REQ-021 When rst_n=0 at a rising clk edge: ALU_Out_q <= 0, zero_q <= 0, out_valid <= 0.
REQ-022 Reset SHALL take priority over in_valid on the same edge; a result in flight SHALL be discarded.
REQ-023 ALU_Out SHALL remain functional while rst_n=0.

Configuration
REQ-024 Macro ALU_SHIFT_EN defined: SLL/SRL/SRA SHALL be implemented per REQ-015.
REQ-025 Macro ALU_SHIFT_EN undefined: no shifter logic SHALL be present, and selects 0010, 0110 and 0111 SHALL give ALU_Out = 0; all other operations are unchanged.

Structure
REQ-026 Package alu_pkg SHALL hold the enum alu_op_e (4-bit, with the REQ-013 codes) and the constant ALU_SHAMT_W = 5.
REQ-027 Shifts SHALL be implemented in sub-module alu_shifter (inputs: data, shamt, op; output: shifted result), instantiated only under ALU_SHIFT_EN.

Verification
REQ-028 ADD with reg1=1, reg2=1 -> ALU_Out=2; with reg1=0, reg2=1 -> 1; with reg1=1, reg2=22 -> 23; each checked 10 ns after the input change, without clocking.
REQ-029 SUB with reg1=0, reg2=1 -> ALU_Out=0xFFFFFFFF; ADD with reg1=0xFFFFFFFF, reg2=1 -> ALU_Out=0.
REQ-030 SLT with reg1=0xFFFFFFFF, reg2=1 -> 1; SLTU with the same operands -> 0.
REQ-031 With ALU_SHIFT_EN defined: SRA reg1=0x80000000, reg2=0x24 -> ALU_Out=0xF8000000; SRL with the same operands -> 0x08000000. Without the macro, both -> 0.
REQ-032 SUB with reg1=5, reg2=5 and in_valid=1 for one edge -> next cycle ALU_Out_q=0, zero_q=1, out_valid=1; the following edge with in_valid=0 -> out_valid=0 and ALU_Out_q held.
REQ-033 rst_n=0 on the same edge as in_valid=1 -> ALU_Out_q=0, zero_q=0, out_valid=0; ALU_sel=1111 -> ALU_Out=0.
